pe_block_seq: RTL and testbench
===============================

Name: pe_block_seq

Overview:
Sequencer that drives one pe_block tile through a complete accumulate pass.
- Accepts a start/done handshake from the layer scheduler.
- Issues weight and data buffer read strobes.
- Generates the pe_block control inputs: clear-accumulator pulse, per-row pass-left mask and output shift, all time-aligned to data arriving at the array.
- Flags when the pe_block result is valid.
- Sits between the tile scheduler and the weight/data buffers feeding one pe_block.

Parameters:
ARRAY_NUM, 3, PEs per row of the driven pe_block; must match the pe_block instance.
TAP_W, 8, width of the tap-count config; tap count range is 1..2^TAP_W-1.
RES_LAT, 2, cycles from the last aligned data cycle at pe_block to oResult being valid.

Ports:
iClk  input  1  clock
iRst  input  1  reset, asynchronous, active-high
iStart  input  1  start request; sampled only in IDLE
iCfsTaps  input  TAP_W  number of weight taps per pass; latched at start
iCfsOutputLeftShift  input  5  result shift; latched at start
oBusy  output  1  high from the first cycle after an accepted start through the oDone cycle
oDone  output  1  one-cycle pulse at pass end
oWeightRdEn  output  1  weight buffer read strobe
oWeightAddr  output  TAP_W  weight tap index
oDataRdEn  output  1  data buffer read strobe
oClearAcc  output  1  to pe_block iClearAcc, aligned
oCfsPassDataLeft  output  ARRAY_NUM-1  to pe_block iCfsPassDataLeft, aligned
oCfsOutputLeftShift  output  5  to pe_block, held from start
oResultValid  output  1  one-cycle pulse: pe_block oResult is valid

Behaviour:
- Reset (async, any state): state=IDLE, all counters=0, every output=0, the latched shift=0. This includes reset mid-pass; no pulses are emitted on release.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN: when iStart=1 and iCfsTaps!=0. iCfsTaps and the shift are latched in this cycle S.
  - iStart with iCfsTaps=0 is ignored; oBusy stays 0.
  - iStart in any state other than IDLE is ignored (no queuing).
- RUN: issue counter i runs 0..T+ARRAY_NUM-2, where T is the latched tap count.
  - i=0 is in cycle S+1.
  - oDataRdEn=1 for every i.
  - oWeightRdEn=1 and oWeightAddr=i only when i<T; otherwise oWeightRdEn=0 and oWeightAddr=0.
  - After the last i, go to DRAIN.
- Buffers return read data one cycle after the strobe. Aligned index c=i arrives at pe_block in cycle S+2+c.
- Control outputs are delayed one register stage to match that arrival:
  - oClearAcc=1 only at aligned c=0.
  - oCfsPassDataLeft bit j (j=0..ARRAY_NUM-2) is 1 when ARRAY_NUM+j <= c <= T-1+j; otherwise 0.
  - Both outputs are 0 outside the aligned window.
- DRAIN: wait so that oResultValid fires in cycle S+T+ARRAY_NUM+RES_LAT. Then go to DONE.
- DONE: lasts one cycle.
  - oResultValid=1, oDone=1, oBusy=1 in this cycle.
  - Next state is IDLE. A new iStart is accepted in the following cycle at the earliest.
- oBusy=1 in cycles S+1 through the DONE cycle inclusive.
- oCfsOutputLeftShift holds the latched value until the next accepted start.
- Counters are TAP_W+clog2(ARRAY_NUM)+1 bits wide. No wrap-around is possible within the legal T range.
- T < ARRAY_NUM+1 is legal. The pass mask bits then stay 0 where the window is empty.

Decomposition:
- Package pe_seq_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the localparam for the shift width (5);
  - the function computing pass-mask bit j from (c, T, ARRAY_NUM).
- One sub-module, pe_seq_align: a one-stage register that delays {clear, pass mask, window-valid} from issue time to arrival time. It resets to 0.

Test Plan:
1. ARRAY_NUM=3, RES_LAT=2, T=9, iStart in cycle 0 -> oWeightAddr 0..8 in cycles 1..9; oDataRdEn in cycles 1..11; oClearAcc in cycle 2; oCfsPassDataLeft over cycles 2..12 is 00,00,00,01,11,11,11,11,11,10,00; oResultValid, oDone and the final oBusy cycle all in cycle 14; IDLE in cycle 15.
2. iStart held high continuously with T=9 -> second pass accepted in cycle 15; its oClearAcc fires in cycle 17; no overlap of the two passes.
3. iStart pulsed in cycles 3 and 14 during a pass -> both ignored; the pass timing is identical to scenario 1.
4. T=0 with iStart -> oBusy stays 0, no strobes. T=2 -> pass mask is 00 throughout; oResultValid fires in cycle 7.
5. iRst asserted asynchronously in cycle 6 of a T=9 pass, released in cycle 8 -> all outputs 0 immediately and stay 0; no oResultValid or oDone; a new start in cycle 9 behaves as scenario 1, shifted by 9 cycles.
6. iCfsOutputLeftShift=7 at start, changed to 3 mid-pass -> oCfsOutputLeftShift stays 7 until the next accepted start.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// Shared types and helpers for the pe_block sequencer.
package pe_seq_pkg;

  localparam int SHIFT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  // Pass-left bit j is active for aligned index c in [array_num+j, t-1+j].
  // Written as c+1 <= t+j so nothing underflows when t is small.
  function automatic logic pass_mask_bit(input int unsigned c,
                                         input int unsigned t,
                                         input int unsigned j,
                                         input int unsigned array_num);
    return (c >= array_num + j) && (c + 1 <= t + j);
  endfunction

endpackage

// File: rtl/pe_seq_align.sv
// One register stage that moves issue-time control to the cycle the
// buffered data reaches the pe_block array.
module pe_seq_align #(
  parameter int ARRAY_NUM = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_clear,
  input  logic [ARRAY_NUM-2:0] issue_mask,
  input  logic                 issue_valid,
  output logic                 arr_clear,
  output logic [ARRAY_NUM-2:0] arr_mask,
  output logic                 arr_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_clear <= 1'b0;
      arr_mask  <= '0;
      arr_valid <= 1'b0;
    end else begin
      arr_clear <= issue_clear;
      arr_mask  <= issue_mask;
      arr_valid <= issue_valid;
    end
  end

endmodule

// File: rtl/pe_block_seq.sv
// Sequencer driving one pe_block tile through a full accumulate pass:
// buffer read strobes, aligned array controls and result-valid flag.
module pe_block_seq
  import pe_seq_pkg::*;
#(
  parameter int ARRAY_NUM = 3,
  parameter int TAP_W     = 8,
  parameter int RES_LAT   = 2
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic [TAP_W-1:0]     iCfsTaps,
  input  logic [SHIFT_W-1:0]   iCfsOutputLeftShift,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oWeightRdEn,
  output logic [TAP_W-1:0]     oWeightAddr,
  output logic                 oDataRdEn,
  output logic                 oClearAcc,
  output logic [ARRAY_NUM-2:0] oCfsPassDataLeft,
  output logic [SHIFT_W-1:0]   oCfsOutputLeftShift,
  output logic                 oResultValid
);

  localparam int CW         = TAP_W + $clog2(ARRAY_NUM) + 1;
  localparam int DRAIN_LAST = (RES_LAT > 0) ? RES_LAT - 1 : 0;

  seq_state_e         state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [TAP_W-1:0]   taps_reg;
  logic [SHIFT_W-1:0] shift_reg;

  logic               accept;
  logic               running;
  logic [CW-1:0]      taps_ext;
  logic [CW-1:0]      last_issue;
  logic               issue_clear;
  logic [ARRAY_NUM-2:0] issue_mask;
  logic               arr_clear;
  logic [ARRAY_NUM-2:0] arr_mask;
  logic               arr_valid;

  assign accept     = (state_reg == IDLE) && iStart && (iCfsTaps != '0);
  assign running    = (state_reg == RUN);
  assign taps_ext   = CW'(taps_reg);
  assign last_issue = taps_ext + CW'(ARRAY_NUM - 2);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      taps_reg  <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        taps_reg  <= iCfsTaps;
        shift_reg <= iCfsOutputLeftShift;
      end
    end
  end

  // One counter serves as issue index in RUN and drain timer in DRAIN.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (cnt_reg == last_issue) begin
          state_next = (RES_LAT == 0) ? DONE : DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_reg == CW'(DRAIN_LAST)) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign oBusy        = (state_reg != IDLE);
  assign oDone        = (state_reg == DONE);
  assign oResultValid = (state_reg == DONE);
  assign oDataRdEn    = running;
  assign oWeightRdEn  = running && (cnt_reg < taps_ext);
  assign oWeightAddr  = oWeightRdEn ? cnt_reg[TAP_W-1:0] : '0;
  assign oCfsOutputLeftShift = shift_reg;

  assign issue_clear = running && (cnt_reg == '0);

  generate
    for (genvar gi = 0; gi < ARRAY_NUM - 1; gi++) begin : g_mask
      assign issue_mask[gi] = running &&
        pass_mask_bit(32'(cnt_reg), 32'(taps_reg), gi, ARRAY_NUM);
    end
  endgenerate

  pe_seq_align #(
    .ARRAY_NUM(ARRAY_NUM)
  ) u_align (
    .clk        (iClk),
    .rst        (iRst),
    .issue_clear(issue_clear),
    .issue_mask (issue_mask),
    .issue_valid(running),
    .arr_clear  (arr_clear),
    .arr_mask   (arr_mask),
    .arr_valid  (arr_valid)
  );

  assign oClearAcc        = arr_clear & arr_valid;
  assign oCfsPassDataLeft = arr_mask & {(ARRAY_NUM-1){arr_valid}};

endmodule

// File: tb/tb_pe_block_seq.sv
// Self-checking bench for pe_block_seq: per-cycle scoreboard of every
// output plus a table of per-pass event counts.
module tb_pe_block_seq;

  localparam int A = 3;
  localparam int TW = 8;
  localparam int L = 2;

  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic          iStart = 1'b0;
  logic [TW-1:0] iCfsTaps = '0;
  logic [4:0]    iCfsOutputLeftShift = '0;
  logic          oBusy, oDone, oWeightRdEn, oDataRdEn, oClearAcc, oResultValid;
  logic [TW-1:0] oWeightAddr;
  logic [A-2:0]  oCfsPassDataLeft;
  logic [4:0]    oCfsOutputLeftShift;

  pe_block_seq #(.ARRAY_NUM(A), .TAP_W(TW), .RES_LAT(L)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iCfsTaps(iCfsTaps),
    .iCfsOutputLeftShift(iCfsOutputLeftShift),
    .oBusy(oBusy), .oDone(oDone), .oWeightRdEn(oWeightRdEn),
    .oWeightAddr(oWeightAddr), .oDataRdEn(oDataRdEn), .oClearAcc(oClearAcc),
    .oCfsPassDataLeft(oCfsPassDataLeft),
    .oCfsOutputLeftShift(oCfsOutputLeftShift), .oResultValid(oResultValid)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int          cyc;
    logic [20:0] vec;
  } exp_t;

  typedef struct {
    int taps;
    int shift;
    int rv_off;
    int wr_cnt;
    int drd_cnt;
    int m0_cnt;
    int m1_cnt;
  } vec_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [4:0] idle_shift = '0;
  int   wr_cnt, drd_cnt, m0_cnt, m1_cnt, rv_cnt, done_cnt, busy_cnt, rv_cyc;

  always @(posedge iClk) cyc <= cyc + 1;

  function automatic logic [20:0] pack_out();
    return {oBusy, oDone, oWeightRdEn, oWeightAddr, oDataRdEn, oClearAcc,
            oCfsPassDataLeft, oResultValid, oCfsOutputLeftShift};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs for every cycle of a pass accepted in cycle s.
  task automatic push_pass(input int s, input int t, input int sh);
    exp_t r;
    for (int k = s + 1; k <= s + t + A + L; k++) begin
      int i, c;
      logic run, wrd, clr, rv;
      logic [TW-1:0] wa;
      logic [A-2:0] m;
      i   = k - s - 1;
      c   = k - s - 2;
      run = (i <= t + A - 2);
      wrd = run && (i < t);
      wa  = wrd ? TW'(i) : '0;
      clr = (c == 0);
      for (int j = 0; j < A - 1; j++)
        m[j] = (c >= A + j) && (c <= t - 1 + j);
      rv  = (k == s + t + A + L);
      r.cyc = k;
      r.vec = {1'b1, rv, wrd, wa, run, clr, m, rv, 5'(sh)};
      exp_q.push_back(r);
    end
  endtask

  always @(negedge iClk) begin
    logic [20:0] exp_v, act_v;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    act_v = pack_out();
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_v = exp_q[0].vec;
      void'(exp_q.pop_front());
      idle_shift = exp_v[4:0];
    end else begin
      exp_v = {16'b0, idle_shift};
    end
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL outputs cycle %0d: got %h expected %h", cyc, act_v, exp_v);
    end
    wr_cnt   += int'(oWeightRdEn);
    drd_cnt  += int'(oDataRdEn);
    m0_cnt   += int'(oCfsPassDataLeft[0]);
    m1_cnt   += int'(oCfsPassDataLeft[1]);
    rv_cnt   += int'(oResultValid);
    done_cnt += int'(oDone);
    busy_cnt += int'(oBusy);
    if (oResultValid) rv_cyc = cyc;
  end

  task automatic zero_counts();
    wr_cnt = 0; drd_cnt = 0; m0_cnt = 0; m1_cnt = 0;
    rv_cnt = 0; done_cnt = 0; busy_cnt = 0; rv_cyc = -1;
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic start_pass(input int t, input int sh, output int s);
    @(posedge iClk);
    #1;
    iStart = 1'b1;
    iCfsTaps = TW'(t);
    iCfsOutputLeftShift = 5'(sh);
    s = cyc;
    if (t != 0) push_pass(s, t, sh);
    @(posedge iClk);
    #1;
    iStart = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    int s, s2;
    tbl[0] = '{9,   5,  14,  9,   11,  6,   6};
    tbl[1] = '{2,   1,  7,   2,   4,   0,   0};
    tbl[2] = '{1,   31, 6,   1,   3,   0,   0};
    tbl[3] = '{4,   2,  9,   4,   6,   1,   1};
    tbl[4] = '{5,   9,  10,  5,   7,   2,   2};
    tbl[5] = '{255, 17, 260, 255, 257, 252, 252};
    zero_counts();

    #2;
    check("reset_outputs", int'(pack_out()), 0);
    repeat (3) @(posedge iClk);
    #3 iRst = 1'b0;

    // Table-driven passes
    for (int n = 0; n < 6; n++) begin
      zero_counts();
      start_pass(tbl[n].taps, tbl[n].shift, s);
      wait_to(s + tbl[n].taps + A + L + 3);
      check($sformatf("rv_count T=%0d", tbl[n].taps), rv_cnt, 1);
      check($sformatf("rv_cycle T=%0d", tbl[n].taps), rv_cyc - s, tbl[n].rv_off);
      check($sformatf("done_count T=%0d", tbl[n].taps), done_cnt, 1);
      check($sformatf("weight_strobes T=%0d", tbl[n].taps), wr_cnt, tbl[n].wr_cnt);
      check($sformatf("data_strobes T=%0d", tbl[n].taps), drd_cnt, tbl[n].drd_cnt);
      check($sformatf("mask0_cycles T=%0d", tbl[n].taps), m0_cnt, tbl[n].m0_cnt);
      check($sformatf("mask1_cycles T=%0d", tbl[n].taps), m1_cnt, tbl[n].m1_cnt);
      $display("pass T=%0d shift=%0d started cycle %0d result at +%0d",
               tbl[n].taps, tbl[n].shift, s, rv_cyc - s);
    end

    // Zero taps: ignored, shift not latched
    zero_counts();
    start_pass(0, 22, s);
    wait_to(s + 8);
    check("t0_busy_cycles", busy_cnt, 0);
    check("t0_data_strobes", drd_cnt, 0);
    $display("start with T=0 at cycle %0d ignored", s);

    // Start held high: second pass begins the cycle after DONE
    wait_to(cyc + 2);
    zero_counts();
    iStart = 1'b1; iCfsTaps = 8'd9; iCfsOutputLeftShift = 5'd4;
    s = cyc;
    push_pass(s, 9, 4);
    push_pass(s + 15, 9, 4);
    wait_to(s + 16);
    iStart = 1'b0;
    wait_to(s + 33);
    check("held_start_passes", done_cnt, 2);
    $display("held start from cycle %0d, second pass at cycle %0d", s, s + 15);

    // Start pulses during a pass are ignored
    zero_counts();
    start_pass(9, 6, s);
    wait_to(s + 3);
    iStart = 1'b1;
    wait_to(s + 4);
    iStart = 1'b0;
    wait_to(s + 14);
    iStart = 1'b1;
    wait_to(s + 15);
    iStart = 1'b0;
    wait_to(s + 20);
    check("pulsed_start_passes", done_cnt, 1);
    check("pulsed_rv_cycle", rv_cyc - s, 14);
    $display("pass at cycle %0d with stray starts at +3 and +14", s);

    // Asynchronous reset mid-pass
    start_pass(9, 12, s);
    wait_to(s + 6);
    zero_counts();
    #2 iRst = 1'b1;
    #1;
    exp_q.delete();
    idle_shift = '0;
    check("async_reset_outputs", int'(pack_out()), 0);
    wait_to(s + 8);
    #2 iRst = 1'b0;
    check("reset_no_result", rv_cnt + done_cnt, 0);
    zero_counts();
    start_pass(9, 12, s2);
    check("restart_cycle", s2 - s, 9);
    wait_to(s2 + 17);
    check("restart_rv_cycle", rv_cyc - s2, 14);
    $display("reset in cycle %0d, restart at cycle %0d", s + 6, s2);

    // Shift input changed mid-pass stays latched
    start_pass(9, 7, s);
    wait_to(s + 5);
    iCfsOutputLeftShift = 5'd3;
    wait_to(s + 17);
    check("shift_held", int'(oCfsOutputLeftShift), 7);
    start_pass(2, 3, s2);
    wait_to(s2 + 9);
    check("shift_relatched", int'(oCfsOutputLeftShift), 3);
    $display("shift 7 held across change, relatched to 3 at cycle %0d", s2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
